// File: rtl/sram_write_buffer.sv
// Posted-write buffer between the cache controller and the SRAM controller.
// Stores queue and drain in the background; loads forward from the queue or go to SRAM first.
module sram_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wrReq,
  input  logic                       rdReq,
  input  logic [31:0]                address,
  input  logic [DATA_W-1:0]          writeData,
  output logic                       ready,
  output logic [DATA_W-1:0]          readData,
  output logic                       sramWrEn,
  output logic                       sramRdEn,
  output logic [31:0]                sramAddress,
  output logic [DATA_W-1:0]          sramWriteData,
  input  logic                       sramReady,
  input  logic [DATA_W-1:0]          sramReadData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e            state_q;
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q;
  logic [29:0]       addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              wr_en_q, rd_en_q;
  logic [31:0]       sram_addr_q;
  logic [DATA_W-1:0] sram_wdata_q;

  logic              rd_act, pop, push, wr_ready, rd_done, rd_miss;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [PW-1:0]     nxt_idx;
  logic              nxt_from_input, more_after_pop;
  logic [29:0]       nxt_addr;
  logic [DATA_W-1:0] nxt_data;

  assign rd_act   = rdReq & ~wrReq;
  assign pop      = (state_q == WRITE) & sramReady;
  assign wr_ready = ~full_q | pop;
  assign push     = wrReq & wr_ready;
  assign rd_done  = (state_q == READ) & sramReady;
  assign rd_miss  = rd_act & ~hit;
  assign count_d  = count_q + CW'(push) - CW'(pop);

  // Scan oldest to newest so the entry closest to the tail wins.
  always_comb begin
    logic [PW-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == address[31:2])) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  // When the only entry pops while a store lands, the new head comes straight from the inputs.
  assign nxt_idx        = head_q + PW'(1);
  assign nxt_from_input = (count_q == CW'(1)) & push;
  assign more_after_pop = (count_q > CW'(1)) | push;
  assign nxt_addr       = nxt_from_input ? address[31:2] : addr_q[nxt_idx];
  assign nxt_data       = nxt_from_input ? writeData     : data_q[nxt_idx];

  always_comb begin
    ready    = 1'b0;
    readData = '0;
    if (!rst) begin
      if (wrReq) begin
        ready = wr_ready;
      end else if (rd_act && hit) begin
        ready    = 1'b1;
        readData = hit_data;
      end else if (rd_act && rd_done) begin
        ready    = 1'b1;
        readData = sramReadData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= address[31:2];
      data_q[tail_q] <= writeData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_miss) begin
            state_q     <= READ;
            rd_en_q     <= 1'b1;
            sram_addr_q <= address;
          end else if (!empty_q) begin
            state_q      <= WRITE;
            wr_en_q      <= 1'b1;
            sram_addr_q  <= {addr_q[head_q], 2'b00};
            sram_wdata_q <= data_q[head_q];
          end
        end
        WRITE: begin
          if (sramReady) begin
            wr_en_q <= 1'b0;
            if (rd_miss) begin
              state_q     <= READ;
              rd_en_q     <= 1'b1;
              sram_addr_q <= address;
            end else if (more_after_pop) begin
              wr_en_q      <= 1'b1;
              sram_addr_q  <= {nxt_addr, 2'b00};
              sram_wdata_q <= nxt_data;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        READ: begin
          if (sramReady) begin
            rd_en_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sramWrEn      = wr_en_q;
  assign sramRdEn      = rd_en_q;
  assign sramAddress   = sram_addr_q;
  assign sramWriteData = sram_wdata_q;
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;

endmodule

// File: tb/tb_sram_write_buffer.sv
// Bench for sram_write_buffer: store/load tables plus multi-cycle sequences,
// with an SRAM responder that scores completed writes and reads against queues.
module tb_sram_write_buffer;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst, wrReq, rdReq;
  logic [31:0]       address;
  logic [DATA_W-1:0] writeData;
  logic              ready;
  logic [DATA_W-1:0] readData;
  logic              sramWrEn, sramRdEn;
  logic [31:0]       sramAddress;
  logic [DATA_W-1:0] sramWriteData;
  logic              sramReady = 1'b0;
  logic [DATA_W-1:0] sramReadData = '0;
  logic [CW-1:0]     count;
  logic              full, empty;

  int tests = 0;
  int fails = 0;
  int lat   = 3;
  bit stall = 1'b0;
  int wcnt  = 0;
  logic [DATA_W-1:0] rd_value = '0;

  typedef struct {logic [31:0] addr; logic [DATA_W-1:0] data;} wr_t;
  typedef struct {logic [31:0] addr; logic [DATA_W-1:0] data; int exp_count;} wr_vec_t;
  typedef struct {logic [31:0] addr; logic [DATA_W-1:0] exp_data;} rd_vec_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  wr_t         m_e;
  wr_vec_t     wv[8];
  rd_vec_t     rv[3];

  sram_write_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .wrReq(wrReq), .rdReq(rdReq), .address(address),
    .writeData(writeData), .ready(ready), .readData(readData),
    .sramWrEn(sramWrEn), .sramRdEn(sramRdEn), .sramAddress(sramAddress),
    .sramWriteData(sramWriteData), .sramReady(sramReady),
    .sramReadData(sramReadData), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s", nm);
  endtask

  // SRAM responder: answers a held request lat cycles later with a one-cycle pulse.
  always @(negedge clk) begin
    if (rst) begin
      sramReady = 1'b0;
      wcnt      = 0;
    end else if (sramReady) begin
      sramReady = 1'b0;
      wcnt      = 0;
    end else if ((sramWrEn || sramRdEn) && !stall) begin
      if (sramWrEn && sramRdEn) fail_now("sram_both_enables");
      wcnt++;
      if (wcnt >= lat) begin
        sramReady = 1'b1;
        if (sramWrEn) begin
          if (exp_wr.size() == 0) fail_now("sram_wr_unexpected");
          else begin
            m_e = exp_wr.pop_front();
            chk("sram_wr_addr", sramAddress, m_e.addr);
            chk("sram_wr_data", sramWriteData, m_e.data);
          end
        end else begin
          if (exp_rd.size() == 0) fail_now("sram_rd_unexpected");
          else chk("sram_rd_addr", sramAddress, exp_rd.pop_front());
          sramReadData = rd_value;
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [DATA_W-1:0] d);
    wrReq = 1'b1; address = a; writeData = d;
    exp_wr.push_back('{a, d});
    @(negedge clk); #1;
    chk("wr_ready", ready, 1'b1);
    @(posedge clk); #1;
    wrReq = 1'b0;
  endtask

  task automatic run_stores(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      do_store(wv[i].addr, wv[i].data);
      chk("wr_count", count, wv[i].exp_count);
    end
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (!empty && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, empty, 1'b1);
    chk({nm, "_count"}, count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; wrReq = 1'b0; rdReq = 1'b0; address = '0; writeData = '0;
    wv[0] = '{32'h100, 32'hA0, 1}; wv[1] = '{32'h104, 32'hA1, 2};
    wv[2] = '{32'h108, 32'hA2, 3}; wv[3] = '{32'h10C, 32'hA3, 4};
    wv[4] = '{32'h600, 32'hB0, 1}; wv[5] = '{32'h604, 32'hB1, 2};
    wv[6] = '{32'h608, 32'hB2, 3}; wv[7] = '{32'h60C, 32'hB3, 4};
    rv[0] = '{32'h200, 32'h22}; rv[1] = '{32'h204, 32'h33}; rv[2] = '{32'h203, 32'h22};

    repeat (2) @(posedge clk);
    #1 wrReq = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_wren", sramWrEn, 1'b0);
    chk("rst_rden", sramRdEn, 1'b0);
    chk("rst_rdata", readData, 0);
    wrReq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Four stores draining with 3-cycle SRAM latency
    lat = 3; stall = 1'b0;
    run_stores(0, 4);
    wait_empty("drain1");

    // Full queue, SRAM stalled, fifth store waits for the pop
    stall = 1'b1;
    run_stores(4, 4);
    chk("full_set", full, 1'b1);
    wrReq = 1'b1; address = 32'h610; writeData = 32'hB4;
    exp_wr.push_back('{32'h610, 32'hB4});
    @(negedge clk); #1;
    chk("full_ready0", ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("full_ready0_b", ready, 1'b0);
    chk("full_count", count, 4);
    @(posedge clk); #1;
    lat = 1; stall = 1'b0;
    @(negedge clk); #1;
    chk("pop_ready1", ready, 1'b1);
    @(posedge clk); #1;
    wrReq = 1'b0;
    chk("pushpop_count", count, 4);
    chk("pushpop_full", full, 1'b1);
    wait_empty("drain2");

    // Forwarding: newest duplicate wins, byte offset ignored
    stall = 1'b1;
    do_store(32'h200, 32'h11);
    do_store(32'h200, 32'h22);
    do_store(32'h204, 32'h33);
    for (int i = 0; i < 3; i++) begin
      rdReq = 1'b1; address = rv[i].addr;
      @(negedge clk); #1;
      chk("hit_ready", ready, 1'b1);
      chk("hit_data", readData, rv[i].exp_data);
      chk("hit_no_rden", sramRdEn, 1'b0);
      @(posedge clk); #1;
    end
    rdReq = 1'b0;
    chk("hit_wren_kept", sramWrEn, 1'b1);
    chk("hit_count", count, 3);
    lat = 2; stall = 1'b0;
    wait_empty("drain3");

    // Read miss behind an in-flight write
    stall = 1'b1;
    do_store(32'h300, 32'h30);
    do_store(32'h304, 32'h34);
    rdReq = 1'b1; address = 32'h400; rd_value = 32'h5A;
    exp_rd.push_back(32'h400);
    @(negedge clk); #1;
    chk("miss_ready0", ready, 1'b0);
    @(posedge clk); #1;
    stall = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!ready && n < 50);
    chk("miss_ready", ready, 1'b1);
    chk("miss_data", readData, 32'h5A);
    chk("miss_rden", sramRdEn, 1'b1);
    chk("miss_wr_pending", exp_wr.size(), 1);
    @(posedge clk); #1;
    rdReq = 1'b0;
    wait_empty("drain4");

    // Asynchronous reset during a write
    stall = 1'b1;
    do_store(32'h700, 32'h70);
    do_store(32'h704, 32'h71);
    do_store(32'h708, 32'h72);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_wren", sramWrEn, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_wren", sramWrEn, 1'b0);
    chk("async_count", count, 0);
    chk("async_empty", empty, 1'b1);
    exp_wr.delete();
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_wren", sramWrEn, 1'b0);
    chk("post_rst_count", count, 0);

    // Simultaneous write and read is a write only
    wrReq = 1'b1; rdReq = 1'b1; address = 32'h500; writeData = 32'h55;
    exp_wr.push_back('{32'h500, 32'h55});
    @(negedge clk); #1;
    chk("wrrd_ready", ready, 1'b1);
    chk("wrrd_rdata", readData, 0);
    @(posedge clk); #1;
    wrReq = 1'b0; rdReq = 1'b0;
    chk("wrrd_count", count, 1);
    chk("wrrd_no_rden", sramRdEn, 1'b0);
    wait_empty("drain6");

    chk("wr_queue_done", exp_wr.size(), 0);
    chk("rd_queue_done", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sram_write_buffer.md
Name: sram_write_buffer

Overview:
- Posted-write buffer between the memory stage's cache controller and the SRAM controller.
- Stores are queued and retire to SRAM in the background, so a store normally costs the pipeline one cycle.
- Loads forward the newest matching queued store. Loads that miss the queue go to SRAM with priority over queued stores.
- ready drives the pipeline freeze (freeze = ~ready).

Parameters:
DEPTH, 4, number of queue entries; power of two, at least 2
DATA_W, 32, width of data words

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
wrReq  in  1  store request from the memory stage
rdReq  in  1  load request from the memory stage
address  in  32  byte address; word compare uses address[31:2]
writeData  in  DATA_W  store data
ready  out  1  request accepted (write) or data valid (read) this cycle
readData  out  DATA_W  load data; valid when ready && rdReq
sramWrEn  out  1  write request to the SRAM controller
sramRdEn  out  1  read request to the SRAM controller
sramAddress  out  32  SRAM request address
sramWriteData  out  DATA_W  SRAM write data
sramReady  in  1  single-cycle completion pulse from the SRAM controller
sramReadData  in  DATA_W  SRAM read data; valid when sramReady
count  out  $clog2(DEPTH+1)  number of occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset, asynchronous and active-high:
  - queue flushed; head, tail and count go to 0; state = IDLE.
  - sramWrEn, sramRdEn, sramAddress, sramWriteData and readData = 0; ready = 0.
  - Asserting rst mid-transaction drops sram enables immediately and discards pending writes.
- Queue: circular FIFO of {addr[31:2], data}.
  - Head and tail pointers wrap modulo DEPTH.
  - Push at tail; pop at head.
- Write request (wrReq=1):
  - ready = !full || pop_this_cycle, combinational.
  - Entry pushes at the clock edge when ready.
  - Push and pop in the same cycle leave count unchanged.
  - Duplicate addresses are appended, not merged.
- Read request (rdReq=1, wrReq=0), hit:
  - Compare address[31:2] against all valid entries.
  - On hit, the newest matching entry (closest to tail) wins; readData = its data and ready = 1 in the same cycle, zero latency.
  - A hit does not change the FSM.
- Read request, miss: ready = 0 until the SRAM read completes.
  - Requester holds rdReq and address stable while ready = 0.
- wrReq and rdReq together: treated as a write only; the read is ignored.
- FSM states:
  - IDLE:
    - read miss -> READ.
    - else !empty -> WRITE.
    - else stay IDLE.
  - WRITE:
    - sramWrEn = 1; sramAddress = {head.addr, 2'b00}; sramWriteData = head.data, all stable until sramReady.
    - On sramReady: pop the head. Then pending read miss -> READ; else count after pop > 0 -> WRITE (next head); else IDLE.
  - READ:
    - sramRdEn = 1; sramAddress = address.
    - On sramReady: readData = sramReadData and ready = 1 in that cycle; -> IDLE.
- Ordering rules:
  - An in-flight write always completes before a read is issued.
  - Read-over-write priority is safe because every read address matching a queued entry hits in the buffer.
- Enables are never both 1; each request is held until sramReady. A sramReady arriving in IDLE is ignored.
- full, empty and count are registered and exact after every edge.

Test Plan:
- Four stores 0x100..0x10C, data 0xA0..0xA3, with sramReady returned 3 cycles after each request -> ready = 1 for all four; count reaches 4; SRAM sees the writes in order; empty afterwards.
- With DEPTH = 4 full and SRAM stalled, issue a fifth store -> ready = 0; on sramReady the pop frees a slot -> ready = 1 that same cycle; count stays 4.
- Stores 0x200 = 0x11, then 0x200 = 0x22, SRAM stalled; load 0x200 -> readData = 0x22, ready = 1 in the same cycle, no sramRdEn.
- Write to 0x300 in flight and 0x304 queued; load 0x400 misses -> the 0x300 write completes, then sramRdEn for 0x400; sramReadData = 0x5A returned with ready = 1; then the 0x304 write drains.
- Assert rst while sramWrEn = 1 with count = 3 -> sramWrEn drops without waiting for a clock edge; count = 0, empty = 1, state IDLE.
- Assert wrReq and rdReq together for 0x500 -> write accepted, no read issued, count increments.
